// File: rtl/cle_pkg.sv
// Shared types and constants for the labeling-engine SRAM arbitration blocks.
package cle_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic SRAM_WEN_WRITE = 1'b0;
  localparam logic SRAM_WEN_READ  = 1'b1;

  localparam int BITMAP_AW = 8;
  localparam int BITMAP_DW = 8;

  localparam int REQ_LOADER = 0;
  localparam int REQ_SCAN   = 1;
  localparam int REQ_BRANCH = 2;

  // Successor of a requester index in round-robin order.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic hit_s;

  // Scan from ptr upward; the first hit wins and masks all later candidates.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      hit_s = !valid && req[(int'(ptr) + k) % N];
      gnt[(int'(ptr) + k) % N] = gnt[(int'(ptr) + k) % N] | hit_s;
      idx   = hit_s ? PW'((int'(ptr) + k) % N) : idx;
      valid = valid | hit_s;
    end
  end

endmodule

// File: rtl/bitmap_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port 256x8 bitmap SRAM.
module bitmap_port_arbiter
  import cle_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = BITMAP_AW,
  parameter int DW       = BITMAP_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      mem_a,
  output logic [DW-1:0]      mem_d,
  output logic               mem_wen,
  input  logic [DW-1:0]      mem_q,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_r;
  logic [PW-1:0]   owner_r;
  logic [PW-1:0]   rr_ptr_r;
  logic [CW-1:0]   lock_cnt_r;
  logic [NREQ-1:0] rvalid_r;

  logic [NREQ-1:0] pick_gnt_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_valid_s;
  logic [NREQ-1:0] gnt_s;
  logic [PW-1:0]   sel_s;
  logic            any_gnt_s;
  logic            lock_end_s;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_r),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Grant selection: lock owner has exclusive access, otherwise round-robin.
  always_comb begin
    gnt_s = '0;
    sel_s = '0;
    if (reset) begin
      gnt_s = '0;
      sel_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_s = pick_gnt_s;
          sel_s = pick_idx_s;
        end
        LOCKED: begin
          gnt_s[owner_r] = req[owner_r];
          sel_s          = owner_r;
        end
        default: begin
          gnt_s = '0;
          sel_s = '0;
        end
      endcase
    end
  end

  assign any_gnt_s = |gnt_s;
  // The cycle that brings the count to LOCK_MAX is the owner's last locked access.
  assign lock_end_s = !req[owner_r] || !lock[owner_r] || (lock_cnt_r >= CW'(LOCK_MAX - 1));

  assign gnt     = gnt_s;
  assign mem_a   = any_gnt_s ? addr[int'(sel_s)*AW +: AW] : '0;
  assign mem_d   = any_gnt_s ? wdata[int'(sel_s)*DW +: DW] : '0;
  assign mem_wen = (any_gnt_s && we[sel_s]) ? SRAM_WEN_WRITE : SRAM_WEN_READ;
  assign rvalid  = reset ? '0 : rvalid_r;
  assign rdata   = mem_q;
  assign busy    = (state_r == LOCKED) | (|req);

  // Arbitration state, round-robin pointer, lock counter and read-return tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      lock_cnt_r <= '0;
      rvalid_r   <= '0;
    end else begin
      rvalid_r <= gnt_s & ~we;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            rr_ptr_r <= PW'(rr_next(int'(pick_idx_s), NREQ));
            if (lock[pick_idx_s]) begin
              state_r    <= LOCKED;
              owner_r    <= pick_idx_s;
              lock_cnt_r <= CW'(1);
            end else begin
              state_r    <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (lock_end_s) begin
            state_r    <= IDLE;
            lock_cnt_r <= '0;
            rr_ptr_r   <= PW'(rr_next(int'(owner_r), NREQ));
          end else begin
            lock_cnt_r <= (lock_cnt_r == CW'(LOCK_MAX)) ? lock_cnt_r : lock_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          lock_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_bitmap_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LM = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_d, mem_q;
  logic [AW-1:0]   mem_a;
  logic            mem_wen, busy;

  logic [7:0] sram [256];
  logic [7:0] exp_mem [256];
  int total, bad;

  // model state for randomized traffic
  int m_ptr, m_owner, m_held, m_pend;
  logic [7:0] m_pdata;

  bitmap_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_a(mem_a),
    .mem_d(mem_d), .mem_wen(mem_wen), .mem_q(mem_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural sram_256x8: WEN 0 writes, 1 reads with one-cycle latency
  always @(posedge clk) begin
    if (mem_wen == 1'b0) sram[mem_a] <= mem_d;
    else mem_q <= sram[mem_a];
  end

  task automatic idle_inputs();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_port(input int i, input logic w, input logic l, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1; we[i] = w; lock[i] = l; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
  endtask

  task automatic to_check();
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_inputs();
    next_cycle(); next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); req = 3'b111;
    next_cycle(); to_check();
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b want=000", gnt); end
    total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL rst_rvalid got=%b want=000", rvalid); end
    total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL rst_wen got=%b want=1", mem_wen); end
    total++; if (mem_a !== 8'h00 || mem_d !== 8'h00) begin bad++; $display("FAIL rst_mem got a=%h d=%h want 00/00", mem_a, mem_d); end
    next_cycle(); idle_inputs(); to_check();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    next_cycle(); reset = 1'b0; to_check();
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL idle_gnt got=%b want=000", gnt); end
    next_cycle();
  endtask

  task automatic test_single_read();
    sram[8'h05] = 8'h3C;
    idle_inputs(); set_port(1, 1'b0, 1'b0, 8'h05, 8'h00); to_check();
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL sr_gnt got=%b want=010", gnt); end
    total++; if (mem_wen !== 1'b1 || mem_a !== 8'h05) begin bad++; $display("FAIL sr_mem got wen=%b a=%h want 1/05", mem_wen, mem_a); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sr_busy got=%b want=1", busy); end
    next_cycle(); idle_inputs(); to_check();
    total++; if (rvalid !== 3'b010) begin bad++; $display("FAIL sr_rvalid got=%b want=010", rvalid); end
    total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL sr_rdata got=%h want=3c", rdata); end
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL sr_gnt_after got=%b want=000", gnt); end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 1'b0, 1'b0, 8'(i), 8'h00);
    for (int c = 0; c < 6; c++) begin
      to_check();
      e = '0; e[c % N] = 1'b1;
      total++; if (gnt !== e) begin bad++; $display("FAIL cont_gnt c=%0d got=%b want=%b", c, gnt, e); end
      next_cycle();
    end
    idle_inputs(); to_check(); next_cycle();
  endtask

  task automatic test_burst_lock();
    sram[8'h10] = 8'h11; sram[8'h14] = 8'h22; sram[8'h18] = 8'h33; sram[8'h00] = 8'h44;
    idle_inputs(); set_port(2, 1'b0, 1'b1, 8'h10, 8'h00); to_check();
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL bl_gnt1 got=%b want=100", gnt); end
    next_cycle();
    set_port(2, 1'b0, 1'b1, 8'h14, 8'h00); set_port(0, 1'b0, 1'b0, 8'h00, 8'h00); to_check();
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL bl_gnt2 got=%b want=100", gnt); end
    total++; if (rvalid !== 3'b100 || rdata !== 8'h11) begin bad++; $display("FAIL bl_rd1 got=%b/%h want 100/11", rvalid, rdata); end
    next_cycle();
    set_port(2, 1'b0, 1'b0, 8'h18, 8'h00); to_check();
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL bl_gnt3 got=%b want=100", gnt); end
    total++; if (rvalid !== 3'b100 || rdata !== 8'h22) begin bad++; $display("FAIL bl_rd2 got=%b/%h want 100/22", rvalid, rdata); end
    next_cycle();
    req[2] = 1'b0; to_check();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL bl_gnt4 got=%b want=001", gnt); end
    total++; if (rvalid !== 3'b100 || rdata !== 8'h33) begin bad++; $display("FAIL bl_rd3 got=%b/%h want 100/33", rvalid, rdata); end
    next_cycle();
    idle_inputs(); to_check();
    total++; if (rvalid !== 3'b001 || rdata !== 8'h44) begin bad++; $display("FAIL bl_rd4 got=%b/%h want 001/44", rvalid, rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [N-1:0] e;
    do_reset();
    set_port(0, 1'b0, 1'b1, 8'h20, 8'h00); set_port(1, 1'b0, 1'b0, 8'h21, 8'h00);
    for (int c = 1; c <= 18; c++) begin
      to_check();
      e = (c == LM + 1) ? 3'b010 : 3'b001;
      total++; if (gnt !== e) begin bad++; $display("FAIL starve_gnt c=%0d got=%b want=%b", c, gnt, e); end
      next_cycle();
    end
    idle_inputs(); to_check(); next_cycle();
  endtask

  task automatic test_write_read();
    idle_inputs(); set_port(0, 1'b1, 1'b0, 8'h7F, 8'hA5); to_check();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL wr_gnt got=%b want=001", gnt); end
    total++; if (mem_wen !== 1'b0 || mem_a !== 8'h7F || mem_d !== 8'hA5) begin bad++; $display("FAIL wr_mem got %b/%h/%h want 0/7f/a5", mem_wen, mem_a, mem_d); end
    next_cycle();
    idle_inputs(); set_port(1, 1'b0, 1'b0, 8'h7F, 8'h00); to_check();
    total++; if (gnt !== 3'b010 || mem_wen !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b/%b want 010/1", gnt, mem_wen); end
    total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL wr_rvalid got=%b want=000", rvalid); end
    next_cycle();
    idle_inputs(); to_check();
    total++; if (rvalid !== 3'b010 || rdata !== 8'hA5) begin bad++; $display("FAIL wrrd_data got=%b/%h want 010/a5", rvalid, rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    idle_inputs(); set_port(1, 1'b0, 1'b1, 8'h05, 8'h00); to_check();
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rmb_gnt1 got=%b want=010", gnt); end
    next_cycle(); to_check();
    total++; if (gnt !== 3'b010 || rvalid !== 3'b010) begin bad++; $display("FAIL rmb_gnt2 got=%b/%b want 010/010", gnt, rvalid); end
    next_cycle(); reset = 1'b1; to_check();
    total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL rmb_rvalid got=%b want=000", rvalid); end
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rmb_gnt_rst got=%b want=000", gnt); end
    next_cycle(); reset = 1'b0;
    idle_inputs(); set_port(0, 1'b0, 1'b0, 8'h40, 8'h00); set_port(1, 1'b0, 1'b0, 8'h41, 8'h00); to_check();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL rmb_gnt_after got=%b want=001", gnt); end
    total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL rmb_rvalid_after got=%b want=000", rvalid); end
    next_cycle(); idle_inputs(); to_check(); next_cycle();
  endtask

  task automatic test_random();
    int g, sticky;
    logic [N-1:0] eg, erv;
    logic ewen;
    logic [7:0] ea, ed;
    do_reset();
    m_ptr = 0; m_owner = -1; m_held = 0; m_pend = -1; m_pdata = 8'h00;
    for (int i = 0; i < 16; i++) begin
      sram[i] = 8'($urandom); exp_mem[i] = sram[i];
    end
    for (int c = 0; c < 500; c++) begin
      req = 3'($urandom_range(0, 7)); we = 3'($urandom_range(0, 7)); lock = 3'($urandom_range(0, 7));
      if (((c / 50) % 2) == 1) begin
        sticky = (c / 100) % N; req[sticky] = 1'b1; lock[sticky] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW] = 8'($urandom_range(0, 15)); wdata[i*DW +: DW] = 8'($urandom);
      end
      to_check();
      g = -1;
      if (m_owner >= 0) begin
        if (req[m_owner]) g = m_owner;
      end else begin
        for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      eg = '0; ewen = 1'b1; ea = 8'h00; ed = 8'h00;
      if (g >= 0) begin
        eg[g] = 1'b1; ewen = ~we[g]; ea = addr[g*AW +: AW]; ed = wdata[g*DW +: DW];
      end
      erv = '0; if (m_pend >= 0) erv[m_pend] = 1'b1;
      total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt, eg); end
      total++; if (mem_wen !== ewen || mem_a !== ea || mem_d !== ed) begin bad++; $display("FAIL rnd_mem c=%0d got %b/%h/%h want %b/%h/%h", c, mem_wen, mem_a, mem_d, ewen, ea, ed); end
      total++; if (busy !== ((m_owner >= 0) || (req != 3'b000))) begin bad++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
      total++; if (rvalid !== erv) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b want=%b", c, rvalid, erv); end
      if (m_pend >= 0) begin
        total++; if (rdata !== m_pdata) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, rdata, m_pdata); end
      end
      m_pend = -1;
      if (g >= 0) begin
        if (we[g]) exp_mem[ea] = ed;
        else begin m_pend = g; m_pdata = exp_mem[ea]; end
      end
      if (m_owner < 0) begin
        if (g >= 0) begin
          m_ptr = (g + 1) % N;
          if (lock[g]) begin m_owner = g; m_held = 1; end
        end
      end else if (!req[m_owner] || !lock[m_owner]) begin
        m_owner = -1;
      end else begin
        m_held++;
        if (m_held >= LM) m_owner = -1;
      end
      next_cycle();
    end
    idle_inputs(); to_check(); next_cycle(); next_cycle();
  endtask

  initial begin
    total = 0; bad = 0; reset = 1'b1; idle_inputs();
    for (int i = 0; i < 256; i++) sram[i] = 8'h00;
    test_reset();
    test_single_read();
    test_contention();
    test_burst_lock();
    test_starvation();
    test_write_read();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitmap_port_arbiter.md
Name: bitmap_port_arbiter

Overview:
Shares one single-port 256x8 bitmap SRAM (sram_256x8, WEN 0 = write, 1 = read) between up to NREQ requesters. Typical requesters are the ROM loader, the raster scanner and the flood-fill/branch engine of the labeling datapath.
- Round-robin arbitration, with an optional burst lock so a requester can finish a multi-access sequence (e.g. a 3-row neighbourhood read) uninterrupted.
- Routes registered read data back to the requester whose read produced it.

Parameters:
NREQ, 3, number of requesters (2..4)
AW, 8, SRAM address width
DW, 8, SRAM data width
LOCK_MAX, 16, max consecutive cycles one requester may hold a lock (anti-starvation)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NREQ  access request per requester; held until granted
we  in  NREQ  1 = write, 0 = read, per requester
addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
wdata  in  NREQ*DW  packed write data
lock  in  NREQ  keep grant next cycle if req also held
gnt  out  NREQ  one-hot grant; command issued to SRAM this cycle
rvalid  out  NREQ  one-hot; rdata valid for that requester this cycle
rdata  out  DW  SRAM read data (mem_q passthrough)
mem_a  out  AW  SRAM address
mem_d  out  DW  SRAM write data
mem_wen  out  1  SRAM WEN (0 = write, 1 = read)
mem_q  in  DW  SRAM Q, valid one cycle after a read command
busy  out  1  lock owner present or any req high

Behaviour:
- Reset: gnt=0, rvalid=0, mem_wen=1, mem_a=0, mem_d=0, rr_ptr=0, owner=none, lock_cnt=0, state=IDLE.
- Reset asserted mid-operation: aborts any burst; an rvalid due the following cycle is suppressed.
- gnt is combinational from req/state/rr_ptr; at most one bit high.
- mem_a/mem_d/mem_wen are combinational muxes of the granted requester. With no grant: mem_wen=1, mem_a=0, mem_d=0 (harmless read).
- Handshake: a transfer completes in the cycle req[i]&gnt[i]. The requester may change addr/we/wdata or drop req the next cycle.
- Read latency: granted read in cycle N gives rvalid[i]=1 in cycle N+1 with rdata=mem_q. Writes never assert rvalid.
- Back-to-back reads from one owner: rvalid is high every cycle, pipelined.
- Arbitration (IDLE): scan req starting at rr_ptr upward with wrap; grant the first set bit. On grant to i, rr_ptr <= (i+1) mod NREQ.
- States:
  - IDLE -> LOCKED when the granted requester has lock=1: owner=i, lock_cnt=1.
  - LOCKED: gnt[owner]=req[owner]; other requests ignored; lock_cnt increments each cycle.
  - LOCKED -> IDLE when req[owner]=0 or lock[owner]=0. That cycle's grant still goes to owner if req[owner]=1.
  - LOCKED -> IDLE forced when lock_cnt==LOCK_MAX. Owner keeps that cycle's access. Next cycle arbitration starts at rr_ptr = owner+1, so owner cannot be re-granted before others with pending req.
- Lock with req=0 in IDLE: ignored.
- Simultaneous req: no write/read priority; round-robin only.
- Same-address write then read on consecutive cycles returns the new data (SRAM behaviour; the arbiter adds no bypass).
- lock_cnt is a $clog2(LOCK_MAX+1)-bit saturating counter, cleared on entering IDLE.
- busy = (state==LOCKED) | (|req).

Decomposition:
- Shared package cle_pkg: arbiter state enum (IDLE, LOCKED), SRAM_WEN_WRITE=0 / SRAM_WEN_READ=1, BITMAP_AW=8, BITMAP_DW=8. Requester index constants: REQ_LOADER=0, REQ_SCAN=1, REQ_BRANCH=2.
- One sub-module: rr_pick (combinational round-robin one-hot picker: req vector + rr_ptr -> one-hot grant + index). Reused by future label-SRAM arbitration.

Test Plan:
- Single read: req[1]=1, we=0, addr=0x05, SRAM preloaded 0x3C -> gnt=3'b010 same cycle, mem_wen=1, mem_a=0x05; next cycle rvalid=3'b010, rdata=0x3C.
- Contention: req=3'b111 held continuously, lock=0, rr_ptr=0 -> grants 001,010,100,001 on successive cycles; each requester granted exactly once per 3 cycles.
- Burst lock: req[2]=1, lock[2]=1 for 3 reads (addr 0x10,0x14,0x18) while req[0]=1 -> gnt=100 for 3 cycles, rvalid[2] on cycles 2-4; gnt=001 on cycle 4 after lock drops.
- Starvation bound (LOCK_MAX=16): req[0]&lock[0] held forever, req[1]=1 -> gnt[0] for 16 cycles, gnt[1] on cycle 17, gnt[0] again on cycle 18.
- Write then read: req[0] write 0xA5 to 0x7F (mem_wen=0, no rvalid), then req[1] read 0x7F -> rvalid[1], rdata=0xA5.
- Reset mid-burst: assert reset in cycle after a granted read inside a lock -> rvalid=0 that cycle, state IDLE, rr_ptr=0, gnt=0 until req resampled.
